pipe5_writeback_stage: RTL
==========================

// Module: pipe5_writeback_stage
// PURPOSE
// - Consumer end of the memory->writeback boundary of the 5-stage RV32I pipeline.
// - Latches the memory-stage result bundle into the MEM/WB pipeline register.
// - Selects the write-back source and drives the register-file write port.
// - Drives the forwarding bus for the hazard unit.
// - Owns the sticky core-halt flag and the retired-instruction counter.
// PARAMETERS
// - RESET_PC4  32'h0000_0000  reset value of the registered pc4/debug field
// PORTS
// - CLK            in   1   core clock, all state on rising edge
// - RST            in   1   asynchronous, active-high reset
// - mem_valid      in   1   memory stage presents a real instruction this cycle
// - mem_wen        in   1   instruction writes rd
// - mem_reg_rd     in   5   destination register
// - mem_w_src      in   3   w_src_t: 0 ALU, 1 LOAD, 2 PC4, 3 LUI, 4 CSR, 5-7 reserved
// - mem_alu_out    in   32  ALU result
// - mem_dload_ext  in   32  sign/zero-extended load data
// - mem_pc4        in   32  PC+4 of the instruction
// - mem_imm_U      in   32  U-immediate, already shifted
// - mem_csr_rdata  in   32  CSR old value
// - mem_halt       in   1   instruction is the halt instruction
// - wb_flush       in   1   squash the entry being latched this cycle
// - rf_wen         out  1   register-file write enable
// - rf_rd          out  5   register-file write address
// - rf_wdata       out  32  register-file write data
// - fwd_valid      out  1   forwarding bus valid (== rf_wen)
// - fwd_rd         out  5   forwarding register (== rf_rd)
// - fwd_data       out  32  forwarding data (== rf_wdata)
// - wb_pc4         out  32  pc4 of the entry in WB, for trace/debug
// - retire         out  1   one-cycle pulse per retired instruction
// - halt           out  1   sticky core halt
// - instret        out  64  retired-instruction count (WB_INSTRET_EN only)
// BEHAVIOUR
// - Reset: pipeline register holds a bubble; every output is 0, except wb_pc4 = RESET_PC4.
// - Latency: one cycle. The bundle sampled at edge N drives rf_* and fwd_* during cycle N+1.
// - Output path: rf_*/fwd_* are a combinational function of the registered bundle only.
//   There is no combinational path from mem_* to any output.
// - Latched as bubble (valid = 0):
//   - mem_valid = 0, or
//   - wb_flush = 1 (flush wins over mem_valid), or
//   - halt already 1.
// - Write-data mux on the registered w_src:
//   - 0 -> alu_out; 1 -> dload_ext; 2 -> pc4; 3 -> imm_U; 4 -> csr_rdata.
//   - 5-7 -> data 32'h0 and rf_wen forced 0.
// - rf_wen = valid & wen & (rd != 0) & legal w_src. Writes to x0 are never issued.
// - retire = valid. A bubble, a wen = 0 instruction and an x0 write all follow this rule:
//   they retire if valid.
// - halt:
//   - Set on the edge that latches a valid entry with mem_halt = 1.
//   - Stays 1 until RST.
//   - The halt entry itself retires but never writes rf.
//   - Every later entry is a bubble.
// - Simultaneous mem_halt and wb_flush: the flush wins and halt is not set.
// - Reset mid-operation: asynchronous clear of the register, halt and instret.
//   A write in flight is dropped. rf_wen drops immediately on RST assertion.
// CONFIGURATION
// - WB_INSTRET_EN defined:
//   - 64-bit instret increments by 1 on every retire.
//   - Wraps 2^64-1 -> 0 and is readable the cycle after the retire pulse.
// - WB_INSTRET_EN undefined:
//   - instret is tied to 64'h0 and no counter flops exist.
//   - All other behaviour is identical.
// TESTING
// - Reset: assert RST mid-stream with a valid ALU write in WB.
//   -> rf_wen = 0, halt = 0, instret = 0 in the same cycle; wb_pc4 = RESET_PC4.
// - ALU write: valid, wen = 1, rd = 5, w_src = 0, alu = 32'hDEAD_BEEF.
//   -> next cycle rf_wen = 1, rf_rd = 5, rf_wdata = 32'hDEAD_BEEF; fwd_* identical.
// - Mux sweep with w_src 1/2/3/4 (load 32'hFFFF_FF80, pc4 32'h104, imm_U 32'h1234_5000,
//   csr 32'h8):
//   -> each value appears on rf_wdata.
//   -> w_src = 6 gives rf_wen = 0 and rf_wdata = 0.
// - x0 and flush cases:
//   - rd = 0 with wen = 1 -> rf_wen = 0, retire = 1.
//   - Valid entry with wb_flush = 1 -> retire = 0, rf_wen = 0.
// - Halt: valid mem_halt, then three valid writes to rd = 7.
//   -> halt = 1 from the next cycle; one retire pulse; zero rf writes to x7.
// - Counter (WB_INSTRET_EN): 10 valid, 3 bubbles, 2 flushed -> instret = 10.
//   - Force the counter to 64'hFFFF_FFFF_FFFF_FFFF and retire one -> instret = 0.

Source files
------------

// File: rtl/pipe5_writeback_stage_if.sv
// Memory-stage -> writeback-stage result bundle of the 5-stage RV32I pipeline.
// master: memory stage (producer); slave: writeback stage (consumer).
interface pipe5_writeback_stage_if;
    logic        mem_valid;
    logic        mem_wen;
    logic [4:0]  mem_reg_rd;
    logic [2:0]  mem_w_src;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_dload_ext;
    logic [31:0] mem_pc4;
    logic [31:0] mem_imm_U;
    logic [31:0] mem_csr_rdata;
    logic        mem_halt;

    modport master (
        output mem_valid, mem_wen, mem_reg_rd, mem_w_src, mem_alu_out,
               mem_dload_ext, mem_pc4, mem_imm_U, mem_csr_rdata, mem_halt
    );

    modport slave (
        input  mem_valid, mem_wen, mem_reg_rd, mem_w_src, mem_alu_out,
               mem_dload_ext, mem_pc4, mem_imm_U, mem_csr_rdata, mem_halt
    );
endinterface

// File: rtl/pipe5_writeback_stage.sv
// Writeback stage: MEM/WB register, write-back mux, forwarding bus, halt flag, instret.
// Optional feature macro: WB_INSTRET_EN enables the 64-bit retired-instruction counter.
module pipe5_writeback_stage #(
    parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe5_writeback_stage_if.slave  mem,
    input  logic                    wb_flush,
    output logic                    rf_wen,
    output logic [4:0]              rf_rd,
    output logic [31:0]             rf_wdata,
    output logic                    fwd_valid,
    output logic [4:0]              fwd_rd,
    output logic [31:0]             fwd_data,
    output logic [31:0]             wb_pc4,
    output logic                    retire,
    output logic                    halt,
    output logic [63:0]             instret
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned SRC_W   = 3;
    localparam int unsigned CNT_W   = 64;

    typedef enum logic [SRC_W-1:0] {
        WSRC_ALU  = 3'd0,
        WSRC_LOAD = 3'd1,
        WSRC_PC4  = 3'd2,
        WSRC_LUI  = 3'd3,
        WSRC_CSR  = 3'd4
    } w_src_t;

    typedef struct packed {
        logic             valid;
        logic             wen;
        logic [REG_W-1:0] rd;
        logic [SRC_W-1:0] w_src;
        logic [XLEN-1:0]  alu_out;
        logic [XLEN-1:0]  dload_ext;
        logic [XLEN-1:0]  pc4;
        logic [XLEN-1:0]  imm_u;
        logic [XLEN-1:0]  csr_rdata;
        logic             halt;
    } wb_bundle_t;

    localparam wb_bundle_t BUBBLE = '{
        valid:     1'b0,
        wen:       1'b0,
        rd:        '0,
        w_src:     '0,
        alu_out:   '0,
        dload_ext: '0,
        pc4:       RESET_PC4,
        imm_u:     '0,
        csr_rdata: '0,
        halt:      1'b0
    };

    wb_bundle_t bundle_q;
    wb_bundle_t bundle_d;
    logic       halt_q;
    logic       halt_d;
    logic [XLEN-1:0] wdata_c;
    logic            src_legal_c;

    // Next MEM/WB entry: flush and an already-halted core both squash to a bubble
    always_comb begin
        bundle_d           = BUBBLE;
        bundle_d.valid     = mem.mem_valid & ~wb_flush & ~halt_q;
        bundle_d.wen       = mem.mem_wen;
        bundle_d.rd        = mem.mem_reg_rd;
        bundle_d.w_src     = mem.mem_w_src;
        bundle_d.alu_out   = mem.mem_alu_out;
        bundle_d.dload_ext = mem.mem_dload_ext;
        bundle_d.pc4       = mem.mem_pc4;
        bundle_d.imm_u     = mem.mem_imm_U;
        bundle_d.csr_rdata = mem.mem_csr_rdata;
        bundle_d.halt      = mem.mem_halt;
        halt_d             = halt_q | (bundle_d.valid & mem.mem_halt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q <= BUBBLE;
            halt_q   <= 1'b0;
        end else begin
            bundle_q <= bundle_d;
            halt_q   <= halt_d;
        end
    end

    // Write-back source select; reserved encodings produce zero and suppress the write
    always_comb begin
        wdata_c     = '0;
        src_legal_c = 1'b1;
        case (w_src_t'(bundle_q.w_src))
            WSRC_ALU:  wdata_c = bundle_q.alu_out;
            WSRC_LOAD: wdata_c = bundle_q.dload_ext;
            WSRC_PC4:  wdata_c = bundle_q.pc4;
            WSRC_LUI:  wdata_c = bundle_q.imm_u;
            WSRC_CSR:  wdata_c = bundle_q.csr_rdata;
            default: begin
                wdata_c     = '0;
                src_legal_c = 1'b0;
            end
        endcase
    end

    // The halt instruction retires but never commits a register write
    always_comb begin
        rf_wen    = bundle_q.valid & bundle_q.wen & (bundle_q.rd != '0)
                  & src_legal_c & ~bundle_q.halt;
        rf_rd     = bundle_q.rd;
        rf_wdata  = wdata_c;
        fwd_valid = rf_wen;
        fwd_rd    = rf_rd;
        fwd_data  = rf_wdata;
        wb_pc4    = bundle_q.pc4;
        retire    = bundle_q.valid;
        halt      = halt_q;
    end

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (bundle_q.valid) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;
`else
    assign instret = CNT_W'(0);
`endif

endmodule
